kim_fifo_skid: RTL and testbench

//  Parametrised synchronous FIFO with a registered valid/ready output stage.

---
 rtl/kim_fifo_skid.sv | 112 +++++++++++
 tb/tb_kim_fifo_skid.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kim_fifo_skid.sv
// kim_fifo_skid: synchronous FIFO with a registered valid/ready output stage.
// DEPTH = 2**ADDR_WIDTH RAM entries plus one output register. s_ready,
// m_valid and m_data all come straight from flops.
// Optional build macro KIM_FIFO_STATUS_EN adds level/almost_full/almost_empty.
module kim_fifo_skid #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
`ifdef KIM_FIFO_STATUS_EN
  ,
  parameter int unsigned AF_THRESH  = 12,
  parameter int unsigned AE_THRESH  = 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef KIM_FIFO_STATUS_EN
  ,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  push;
  logic                  load;
  logic                  m_valid_nxt;

  // Handshake decode and next occupancy; a push into an empty RAM is never bypassed.
  always_comb begin
    push        = s_valid & s_ready;
    load        = (~m_valid | m_ready) & (count != '0);
    count_nxt   = count;
    m_valid_nxt = m_valid;
    if (push && !load) begin
      count_nxt = count + CW'(1);
    end else if (!push && load) begin
      count_nxt = count - CW'(1);
    end
    if (load) begin
      m_valid_nxt = 1'b1;
    end else if (m_ready) begin
      m_valid_nxt = 1'b0;
    end
  end

  // RAM write port; contents need no reset since pointers and count gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Pointers, occupancy and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        m_data <= mem[rd_ptr];
      end
      count   <= count_nxt;
      m_valid <= m_valid_nxt;
      s_ready <= (count_nxt != CW'(DEPTH));
    end
  end

`ifdef KIM_FIFO_STATUS_EN
  logic [CW-1:0] level_nxt;

  // Total words held after this edge: RAM occupancy plus the output register.
  always_comb begin
    level_nxt = count_nxt + CW'(m_valid_nxt);
  end

  // Registered level and threshold flags, computed from the next level.
  always_ff @(posedge clk) begin
    if (rst) begin
      level        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      level        <= level_nxt;
      almost_full  <= (level_nxt >= CW'(AF_THRESH));
      almost_empty <= (level_nxt <= CW'(AE_THRESH));
    end
  end
`endif

endmodule

// File: tb/tb_kim_fifo_skid.sv
// Self-checking bench for kim_fifo_skid: queue-based reference model compared
// every cycle, an end-to-end scoreboard, and directed literal expectations.
`timescale 1ns/1ps
module tb_kim_fifo_skid;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
`ifdef KIM_FIFO_STATUS_EN
  logic [4:0] level;
  logic       almost_full;
  logic       almost_empty;
`endif

  kim_fifo_skid #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef KIM_FIFO_STATUS_EN
    , .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words in RAM as a queue, plus the output slot.
  logic [7:0] mq[$];
  bit         mdl_ov = 1'b0;
  logic [7:0] mdl_od = 8'h00;
  bit         mdl_sr = 1'b0;
  bit         mdl_on = 1'b0;
  bit         do_push;
  bit         do_load;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mdl_ov = 1'b0;
      mdl_od = 8'h00;
      mdl_sr = 1'b0;
      mdl_on = 1'b1;
    end else if (mdl_on) begin
      do_push = s_valid && mdl_sr;
      do_load = (!mdl_ov || m_ready) && (mq.size() != 0);
      if (do_load) begin
        mdl_od = mq.pop_front();
        mdl_ov = 1'b1;
      end else if (m_ready) begin
        mdl_ov = 1'b0;
      end
      if (do_push) mq.push_back(s_data);
      mdl_sr = (mq.size() != DEPTH);
    end
  end

  // Per-cycle compare, output-hold rule, and end-to-end scoreboard.
  logic [7:0] sb[$];
  bit         prev_hold = 1'b0;
  logic [7:0] prev_md;
  logic [7:0] exp_word;
`ifdef KIM_FIFO_STATUS_EN
  int         mdl_lvl;
`endif

  always @(negedge clk) begin
    if (mdl_on) begin
      check("model_s_ready", 32'(s_ready), 32'(mdl_sr));
      check("model_m_valid", 32'(m_valid), 32'(mdl_ov));
      check("model_m_data", 32'(m_data), 32'(mdl_od));
`ifdef KIM_FIFO_STATUS_EN
      mdl_lvl = mq.size() + int'(mdl_ov);
      check("model_level", 32'(level), 32'(mdl_lvl));
      check("model_almost_full", 32'(almost_full), 32'(mdl_lvl >= 12));
      check("model_almost_empty", 32'(almost_empty), 32'(mdl_lvl <= 2));
`endif
      if (prev_hold) begin
        check("hold_m_valid", 32'(m_valid), 32'd1);
        check("hold_m_data", 32'(m_data), 32'(prev_md));
      end
      prev_hold = m_valid && !m_ready && !rst;
      prev_md   = m_data;
      if (rst) begin
        sb.delete();
      end else begin
        if (s_valid && s_ready) sb.push_back(s_data);
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got word 0x%0h expected none at %0t", m_data, $time);
          end else begin
            exp_word = sb.pop_front();
            check("sb_order", 32'(m_data), 32'(exp_word));
          end
        end
      end
    end
  end

  int acc;
  int outs;
  int cyc;

  initial begin
    // Reset for three cycles, then idle.
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_rst", 32'(s_ready), 32'd1);
    check("idle_m_valid", 32'(m_valid), 32'd0);

    // Five back-to-back words with the sink always ready.
    m_ready = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      s_valid = (e <= 5);
      s_data  = 8'(e);
      @(posedge clk); #1;
      if (e == 1) begin
        check("t2_latency_early", 32'(m_valid), 32'd0);
      end else if (e <= 6) begin
        check("t2_m_valid", 32'(m_valid), 32'd1);
        check("t2_m_data", 32'(m_data), 32'(e - 1));
      end else begin
        check("t2_idle", 32'(m_valid), 32'd0);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;

    // Fill with the sink stalled: capacity is RAM plus output register.
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h40 + acc);
      @(negedge clk);
      if (s_ready) acc++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("t3_accepted", 32'(acc), 32'd17);
    check("t3_full_s_ready", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    outs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) outs++;
      @(posedge clk); #1;
      if (i == 0) check("t3_s_ready_rerise", 32'(s_ready), 32'd1);
    end
    check("t3_drained", 32'(outs), 32'd17);
    m_ready = 1'b0;

    // Random traffic at 50% source and sink activity.
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    check("t4_words_accepted", 32'(acc), 32'd10000);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t4_drained_m_valid", 32'(m_valid), 32'd0);

    // Reset while holding eight words, then a fresh word must lead.
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 8'(8'h10 + i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("t5_holding", 32'(m_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_m_valid", 32'(m_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_s_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (m_valid) break;
      @(posedge clk); #1;
    end
    check("t5_first_valid", 32'(m_valid), 32'd1);
    check("t5_first_data", 32'(m_data), 32'hAA);
    m_ready = 1'b0;

`ifdef KIM_FIFO_STATUS_EN
    // Status thresholds: fill to 12, drain to 2.
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_almost_empty", 32'(almost_empty), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_data = 8'(8'h60 + i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("t6_level_full", 32'(level), 32'd12);
    check("t6_almost_full", 32'(almost_full), 32'd1);
    check("t6_not_almost_empty", 32'(almost_empty), 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (level == 5'd2) break;
    end
    m_ready = 1'b0;
    check("t6_level_low", 32'(level), 32'd2);
    check("t6_almost_empty", 32'(almost_empty), 32'd1);
    check("t6_not_almost_full", 32'(almost_full), 32'd0);
    @(posedge clk); #1;
    check("t6_level_stable", 32'(level), 32'd2);
`endif

    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
